radix_multiplier: RTL and testbench
===================================

# radix_multiplier

- Iterative shift-add multiplier producing a 2×DATA_WIDTH product, retiring BITS_PER_CYCLE multiplier bits per clock.
- Generational successor to the team's single-mode Multiplier: adds a per-operation signed/unsigned mode, configurable radix, a one-cycle Done strobe and an optional early-exit path.
- Sits in the arithmetic component library and is driven by the same Start/Ready handshake, so existing callers port with only a reset hookup.

## Interface
- DATA_WIDTH, 16: operand width; must be ≥ 2.
- BITS_PER_CYCLE, 1: multiplier bits retired per RUN cycle; must be 1, 2 or 4 and divide DATA_WIDTH.
- Clocking and reset (fixed): one clock; reset is synchronous and active-low.
- Clk  in  1  rising-edge clock.
- NReset  in  1  synchronous active-low reset, sampled on Clk rise.
- InputA  in  DATA_WIDTH  multiplicand; sampled only on accept.
- InputB  in  DATA_WIDTH  multiplier; sampled only on accept.
- Signed  in  1  1 = operands are two's complement; sampled only on accept.
- Start  in  1  request; accepted when Start=1 and Ready=1 at a Clk rise.
- Ready  out  1  high while idle, i.e. able to accept Start.
- Done  out  1  one-cycle strobe when Product is updated.
- Product  out  2*DATA_WIDTH  result; holds until the next completion.

## Operation
- States:
  - IDLE: Ready=1. On accept, capture operands and go to RUN.
  - RUN: Ready=0.
  - FINISH: Ready=0, single cycle, then IDLE.
- Accept:
  - If Signed=1, store |InputA| and |InputB| as DATA_WIDTH-bit unsigned magnitudes (|−2^(W−1)| = 2^(W−1) fits), plus NegFlag = A[W−1] XOR B[W−1].
  - If Signed=0, store the operands raw with NegFlag=0.
  - Clear the accumulator and the cycle counter.
- RUN, each cycle:
  - Accumulator += Mcand × (low BITS_PER_CYCLE bits of the multiplier register) << (count × BITS_PER_CYCLE).
  - Shift the multiplier register right by BITS_PER_CYCLE and increment count.
  - Leave RUN after N = DATA_WIDTH/BITS_PER_CYCLE cycles.
- All arithmetic is done in 2×DATA_WIDTH bits, unsigned; no overflow is possible.
- FINISH:
  - Product ← NegFlag ? −Acc : Acc, two's complement modulo 2^(2W).
  - Done=1 for this cycle only; next state is IDLE.
- Start while Ready=0 is ignored; there is no queuing.
- Start held high continuously gives back-to-back operations, each accepted on the first cycle Ready=1.
- Operands may change freely after accept.
- Signed=1 with a zero operand yields Product=0, never −0.

## Timing
- Reset values: Ready=1, Done=0, Product=0, state IDLE, accumulator and counter cleared.
- Reset mid-operation aborts it: no Done pulse, Product=0 on the following cycle.
- Reset wins over a simultaneous Start.
- Accept at edge k:
  - Ready=0 from edge k.
  - RUN occupies edges k+1 … k+N.
  - FINISH is entered at edge k+N; Done=1 and the new Product become visible after edge k+N+1.
  - Ready returns to 1 in the same cycle as Done; the next Start can be accepted at edge k+N+2.
- Total latency is N+1 cycles from accept to Done. Example: DATA_WIDTH=16 with BITS_PER_CYCLE=1 gives 17; with 4 gives 5.
- Product is stable everywhere except the single update edge.

## Configuration
- MULT_EARLY_EXIT_EN defined:
  - RUN also exits at the end of any cycle where the shifted multiplier register is zero.
  - Minimum is 1 RUN cycle, maximum N; latency = 1 + ceil((msb index of |B| + 1)/BITS_PER_CYCLE), or 2 when B=0.
  - Results are identical to the non-early-exit build.
- MULT_EARLY_EXIT_EN undefined: latency is always N+1, fully deterministic.

## Test plan
- Reset mid-RUN: NReset=0 for 1 cycle after accepting 7×9 → Ready=1, Done never pulses, Product=0.
- Unsigned (W=16, BPC=1, no early exit): A=4, B=5, Signed=0 → Done exactly 17 cycles after accept, Product=20.
- Unsigned extremes: A=0xFFFF, B=0xFFFF, Signed=0 → Product=0xFFFE0001; repeat with BPC=2 and 4 → same value, latency 9 and 5.
- Signed corners:
  - −1×1 → 0xFFFFFFFF.
  - −32768×−32768 → 0x40000000.
  - −3×0 → 0.
- Back-to-back with Start held high: 3×3 then 2×8 → two single-cycle Done pulses 18 cycles apart, Product 9 then 16; a Start pulse mid-RUN is ignored.
- Early exit with MULT_EARLY_EXIT_EN, BPC=1: A=4, B=5 → Done 4 cycles after accept, Product=20; B=0 → Done after 2 cycles, Product=0.

Source files
------------

// File: rtl/radix_multiplier.sv
// radix_multiplier
//   Iterative shift-add multiplier. Retires BITS_PER_CYCLE multiplier bits
//   per RUN cycle and produces a 2*DATA_WIDTH product. Signed operation is
//   done on magnitudes, with the sign applied once at the end.
//
// Parameters
//   DATA_WIDTH      operand width (>= 2)
//   BITS_PER_CYCLE  multiplier bits per RUN cycle: 1, 2 or 4, dividing DATA_WIDTH
//
// Optional feature macro
//   MULT_EARLY_EXIT_EN  leave RUN as soon as the remaining multiplier bits are zero
//
// Ports
//   Clk      in   rising-edge clock
//   NReset   in   synchronous active-low reset
//   InputA   in   multiplicand, sampled on accept
//   InputB   in   multiplier, sampled on accept
//   Signed   in   1 = two's complement operands, sampled on accept
//   Start    in   request, accepted when Start && Ready at a Clk rise
//   Ready    out  idle, able to accept Start
//   Done     out  one-cycle strobe when Product updates
//   Product  out  result, held until the next completion

// Partial product of the multiplicand and one radix digit.
module radix_digit_pp #(
    parameter int W = 16,
    parameter int B = 1
) (
    input  logic [W-1:0]   mcand,
    input  logic [B-1:0]   digit,
    output logic [W+B-1:0] pp
);
    logic [B-1:0][W+B-1:0] term;

    genvar i;
    generate
        for (i = 0; i < B; i++) begin : g_term
            assign term[i] = digit[i] ? ({{B{1'b0}}, mcand} << i) : '0;
        end
    endgenerate

    always_comb begin
        pp = '0;
        for (int j = 0; j < B; j++) pp = pp + term[j];
    end
endmodule

module radix_multiplier #(
    parameter int DATA_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    Clk,
    input  logic                    NReset,
    input  logic [DATA_WIDTH-1:0]   InputA,
    input  logic [DATA_WIDTH-1:0]   InputB,
    input  logic                    Signed,
    input  logic                    Start,
    output logic                    Ready,
    output logic                    Done,
    output logic [2*DATA_WIDTH-1:0] Product
);
    localparam int W    = DATA_WIDTH;
    localparam int BPC  = BITS_PER_CYCLE;
    localparam int N    = W / BPC;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int LOGB = $clog2(BPC);
    localparam int PW   = 2 * W;
    localparam int SW   = $clog2(PW) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    typedef struct packed {
        logic [W-1:0] mcand;
        logic [W-1:0] mplier;
        logic         neg;
    } op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_in;
    logic [PW-1:0] acc_q;
    logic [CW-1:0] count_q;

    logic [W+BPC-1:0] pp;
    logic [SW-1:0]    sh;
    logic [PW-1:0]    acc_step;
    logic [W-1:0]     mplier_shr;
    logic             run_last;

    // Operand capture: signed operands are reduced to magnitudes. The most
    // negative value negates to itself, which read as unsigned is exactly
    // its magnitude.
    always_comb begin
        op_in.mcand  = (Signed && InputA[W-1]) ? -InputA : InputA;
        op_in.mplier = (Signed && InputB[W-1]) ? -InputB : InputB;
        op_in.neg    = Signed && (InputA[W-1] ^ InputB[W-1]);
    end

    radix_digit_pp #(.W(W), .B(BPC)) u_pp (
        .mcand (op_q.mcand),
        .digit (op_q.mplier[BPC-1:0]),
        .pp    (pp)
    );

    // BPC is a power of two, so the digit weight is count << log2(BPC).
    always_comb begin
        sh         = SW'(count_q) << LOGB;
        acc_step   = acc_q + (PW'(pp) << sh);
        mplier_shr = op_q.mplier >> BPC;
`ifdef MULT_EARLY_EXIT_EN
        run_last   = (count_q == LAST) || (mplier_shr == '0);
`else
        run_last   = (count_q == LAST);
`endif
    end

    always_comb begin
        state_d = state_q;
        Ready   = 1'b0;
        case (state_q)
            IDLE: begin
                Ready = 1'b1;
                if (Start) state_d = RUN;
            end
            RUN:     if (run_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!NReset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            count_q <= '0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            state_q <= state_d;
            Done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        op_q    <= op_in;
                        acc_q   <= '0;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    acc_q       <= acc_step;
                    op_q.mplier <= mplier_shr;
                    count_q     <= count_q + CW'(1);
                end
                FINISH: begin
                    // Negating zero gives zero, so a signed zero product
                    // never comes out as a distinct -0.
                    Product <= op_q.neg ? -acc_q : acc_q;
                    Done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_radix_multiplier.sv
module tb_radix_multiplier;
    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] a, b;
    logic        s, st;
    logic        rdy [3];
    logic        dn  [3];
    logic [31:0] pr  [3];
    int          bpcv [3] = '{1, 2, 4};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    radix_multiplier #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) u_b1 (
        .Clk(clk), .NReset(nrst), .InputA(a), .InputB(b), .Signed(s),
        .Start(st), .Ready(rdy[0]), .Done(dn[0]), .Product(pr[0]));
    radix_multiplier #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2)) u_b2 (
        .Clk(clk), .NReset(nrst), .InputA(a), .InputB(b), .Signed(s),
        .Start(st), .Ready(rdy[1]), .Done(dn[1]), .Product(pr[1]));
    radix_multiplier #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) u_b4 (
        .Clk(clk), .NReset(nrst), .InputA(a), .InputB(b), .Signed(s),
        .Start(st), .Ready(rdy[2]), .Done(dn[2]), .Product(pr[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept-to-Done latency in cycles.
    function automatic int explat(input int bpc, input logic [15:0] bb, input logic ss);
`ifdef MULT_EARLY_EXIT_EN
        logic [15:0] m;
        int msb;
        m   = (ss && bb[15]) ? -bb : bb;
        msb = -1;
        for (int i = 0; i < 16; i++) if (m[i]) msb = i;
        if (msb < 0) return 2;
        return 1 + (msb + bpc) / bpc;
`else
        return 16 / bpc + 1;
`endif
    endfunction

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                          input logic [31:0] ep, input string tag);
        int          t   [3];
        int          cnt [3];
        logic [31:0] p   [3];
        for (int i = 0; i < 3; i++) begin t[i] = -1; cnt[i] = 0; p[i] = '0; end
        @(negedge clk);
        a = ia; b = ib; s = is; st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0; a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    cnt[i]++;
                    if (t[i] < 0) begin
                        t[i] = c;
                        p[i] = pr[i];
                        chk($sformatf("%s_rdy_at_done%0d", tag, i), 64'(rdy[i]), 64'(1));
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lat%0d", tag, i), 64'(t[i]), 64'(explat(bpcv[i], ib, is)));
            chk($sformatf("%s_prod%0d", tag, i), 64'(p[i]), 64'(ep));
            chk($sformatf("%s_pulses%0d", tag, i), 64'(cnt[i]), 64'(1));
            chk($sformatf("%s_hold%0d", tag, i), 64'(pr[i]), 64'(ep));
        end
    endtask

    initial begin
        int n, t1, t2, cntd;
        logic [31:0] p1, p2;
        nrst = 1'b0; a = '0; b = '0; s = 1'b0; st = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'(1));
            chk($sformatf("rst_done%0d", i), 64'(dn[i]), 64'(0));
            chk($sformatf("rst_prod%0d", i), 64'(pr[i]), 64'(0));
        end
        // Reset wins over a simultaneous Start.
        st = 1'b1; a = 16'd3; b = 16'd3;
        @(posedge clk);
        #1;
        chk("rst_vs_start_ready", 64'(rdy[0]), 64'(1));
        st = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        run_op(16'd4, 16'd5, 1'b0, 32'd20, "u4x5");

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        a = 16'd7; b = 16'd9; s = 1'b0; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_ready%0d", i), 64'(rdy[i]), 64'(1));
            chk($sformatf("midrst_prod%0d", i), 64'(pr[i]), 64'(0));
        end
        nrst = 1'b1;
        cntd = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (dn[0] || dn[1] || dn[2]) cntd++;
        end
        chk("midrst_no_done", 64'(cntd), 64'(0));
        chk("midrst_prod_after", 64'(pr[0]), 64'(0));

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "uffff");
        run_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, "u1234");
        run_op(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, "sm1x1");
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "smin");
        run_op(16'hFFFD, 16'h0000, 1'b1, 32'h00000000, "sm3x0");
        run_op(16'h0003, 16'hFFF9, 1'b1, 32'hFFFFFFEB, "s3xm7");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "sm1xm1");

        // Back-to-back with Start held high.
        @(negedge clk);
        a = 16'd3; b = 16'd3; s = 1'b0; st = 1'b1;
        @(posedge clk);
        #1 a = 16'd2; b = 16'd8;
        n = 0; t1 = -1; t2 = -1; p1 = '0; p2 = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (dn[0]) begin
                n++;
                if (n == 1) begin t1 = c; p1 = pr[0]; end
                if (n == 2) begin t2 = c; p2 = pr[0]; st = 1'b0; break; end
            end
        end
        st = 1'b0;
        chk("b2b_lat1", 64'(t1), 64'(explat(1, 16'd3, 1'b0)));
        chk("b2b_gap", 64'(t2 - t1), 64'(explat(1, 16'd8, 1'b0) + 1));
        chk("b2b_prod1", 64'(p1), 64'(9));
        chk("b2b_prod2", 64'(p2), 64'(16));
        @(posedge clk);
        #1;
        chk("b2b_done_low", 64'(dn[0]), 64'(0));
        repeat (40) @(posedge clk);

        // A Start pulse during RUN is ignored, not queued.
        @(negedge clk);
        a = 16'd4; b = 16'd5; s = 1'b0; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        @(posedge clk);
        #1 a = 16'd9; b = 16'd9; st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        n = 0; t1 = -1; p1 = '0;
        for (int c = 3; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (dn[0]) begin
                n++;
                if (n == 1) begin t1 = c; p1 = pr[0]; end
            end
        end
        chk("ign_lat", 64'(t1), 64'(explat(1, 16'd5, 1'b0)));
        chk("ign_prod", 64'(p1), 64'(20));
        chk("ign_pulses", 64'(n), 64'(1));
        chk("ign_ready", 64'(rdy[0]), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
